// File: rtl/eth_lb_pkg.sv
// eth_lb_pkg: states, fail codes, pattern table and XGMII idle constants for the PHY loopback self-test
package eth_lb_pkg;
   typedef enum logic [2:0] {IDLE, RESET_PHY, WAIT_LOCK, SEND, PRBS, DONE, FAIL} state_t;
   typedef enum logic [1:0] {CHK_ALIGN, CHK_CHECK, CHK_FIN} chk_state_t;
   localparam logic [2:0] FC_NONE  = 3'd0;
   localparam logic [2:0] FC_LOCK  = 3'd1;
   localparam logic [2:0] FC_ALIGN = 3'd2;
   localparam logic [2:0] FC_LOST  = 3'd3;
   localparam logic [2:0] FC_PRBS  = 3'd4;
   localparam logic [63:0] IDLE_WORD = 64'h0707070707070707;
   localparam logic [7:0] IDLE_CTRL = 8'hFF;
   localparam logic [63:0] PAT [0:5] = '{
      64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0000, 64'h5555_5555_5555_5555,
      64'hAAAA_AAAA_AAAA_AAAA, 64'hFEFE_FEFE_FEFE_FEFE, 64'h0123_4567_89AB_CDEF};
   function automatic logic [2:0] pat_next(input logic [2:0] i);
      return (i == 3'd5) ? 3'd0 : i + 3'd1;
   endfunction
endpackage

// File: rtl/eth_lb_pattern_chk.sv
// eth_lb_pattern_chk: aligns to the first pattern word on XGMII rx, then checks PATTERN_COUNT words
module eth_lb_pattern_chk
   import eth_lb_pkg::*;
#(
   parameter int DATA_WIDTH    = 64,
   parameter int CTRL_WIDTH    = 8,
   parameter int PATTERN_COUNT = 256,
   parameter int ALIGN_TIMEOUT = 64
)(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  enable,
   input  logic                  clear,
   input  logic [DATA_WIDTH-1:0] rxd,
   input  logic [CTRL_WIDTH-1:0] rxc,
   output logic                  match,
   output logic                  word_done,
   output logic                  align_timeout,
   output logic [15:0]           err_count
);
   chk_state_t  st;
   logic [2:0]  j;
   logic [31:0] wcnt, acnt;
   logic        mismatch;
   // Word compare against the expected pattern and status pulses from the registered sub-state
   always_comb begin
      match         = (rxc == '0) && (rxd == DATA_WIDTH'(PAT[0]));
      mismatch      = (rxc != '0) || (rxd != DATA_WIDTH'(PAT[j]));
      word_done     = (st == CHK_FIN);
      align_timeout = enable && (st == CHK_ALIGN) && !match && (acnt == ALIGN_TIMEOUT - 1);
   end
   // Align/check sub-FSM; err_count survives disable so the result is held after the run
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st        <= CHK_ALIGN;
         j         <= '0;
         wcnt      <= '0;
         acnt      <= '0;
         err_count <= '0;
      end else begin
         if (clear) err_count <= '0;
         if (!enable) begin
            st   <= CHK_ALIGN;
            j    <= '0;
            wcnt <= '0;
            acnt <= '0;
         end else if (st == CHK_ALIGN) begin
            acnt <= acnt + 1;
            if (match) begin
               st   <= CHK_CHECK;
               j    <= 3'd1;
               wcnt <= 32'd1;
            end
         end else if (st == CHK_CHECK) begin
            if (mismatch && err_count != 16'hFFFF) err_count <= err_count + 16'd1;
            j    <= pat_next(j);
            wcnt <= wcnt + 1;
            if (wcnt == PATTERN_COUNT - 1) st <= CHK_FIN;
         end
      end
   end
endmodule

// File: rtl/eth_phy_lb_ctrl.sv
// eth_phy_lb_ctrl: serdes-loopback self-test sequencer for the 10G PHY; PRBS31 phase built with `LB_CTRL_PRBS_EN
module eth_phy_lb_ctrl
   import eth_lb_pkg::*;
#(
   parameter int DATA_WIDTH    = 64,
   parameter int CTRL_WIDTH    = 8,
   parameter int RST_CYCLES    = 16,
   parameter int LOCK_TIMEOUT  = 4096,
   parameter int PATTERN_COUNT = 256,
   parameter int ALIGN_TIMEOUT = 64
`ifdef LB_CTRL_PRBS_EN
   ,parameter int PRBS_CYCLES  = 1024
`endif
)(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   output logic                  phy_tx_rst,
   output logic                  phy_rx_rst,
   output logic [DATA_WIDTH-1:0] xgmii_txd,
   output logic [CTRL_WIDTH-1:0] xgmii_txc,
   input  logic [DATA_WIDTH-1:0] xgmii_rxd,
   input  logic [CTRL_WIDTH-1:0] xgmii_rxc,
   input  logic                  rx_block_lock,
   input  logic                  rx_high_ber,
   input  logic [6:0]            rx_error_count,
   output logic                  cfg_tx_prbs31_enable,
   output logic                  cfg_rx_prbs31_enable,
   output logic                  busy,
   output logic                  done,
   output logic                  pass,
   output logic [15:0]           err_count,
   output logic [2:0]            fail_code
);
   state_t      state;
   logic [31:0] cnt, tx_cnt;
   logic [4:0]  lock_cnt;
   logic [2:0]  tx_idx;
   logic        lock_ok, lock_hit, term_ok, word_done, align_timeout, unused_match;
   logic [2:0]  term_fc;
`ifdef LB_CTRL_PRBS_EN
   logic        prbs_on, prbs_err, late_err, prbs_end, prbs_bad;
   assign cfg_tx_prbs31_enable = prbs_on;
   assign cfg_rx_prbs31_enable = prbs_on;
`else
   logic        unused_err;
   assign unused_err = ^rx_error_count;
   assign cfg_tx_prbs31_enable = 1'b0;
   assign cfg_rx_prbs31_enable = 1'b0;
`endif

   eth_lb_pattern_chk #(
      .DATA_WIDTH(DATA_WIDTH), .CTRL_WIDTH(CTRL_WIDTH),
      .PATTERN_COUNT(PATTERN_COUNT), .ALIGN_TIMEOUT(ALIGN_TIMEOUT)
   ) u_chk (
      .clk(clk), .rst_n(rst_n), .enable(state == SEND),
      .clear(start && (state == IDLE || state == DONE || state == FAIL)),
      .rxd(xgmii_rxd), .rxc(xgmii_rxc), .match(unused_match), .word_done(word_done),
      .align_timeout(align_timeout), .err_count(err_count)
   );

   // Terminal decision: lock loss outranks every other exit in the same cycle
   always_comb begin
      lock_ok  = rx_block_lock && !rx_high_ber;
      lock_hit = lock_ok && (lock_cnt == 5'd15);
`ifdef LB_CTRL_PRBS_EN
      late_err = (state == PRBS) && (cnt >= PRBS_CYCLES / 2) && (rx_error_count != '0);
      prbs_end = (state == PRBS) && (cnt == PRBS_CYCLES - 1);
      prbs_bad = prbs_err || late_err;
      term_ok  = prbs_end && !prbs_bad;
`else
      term_ok  = (state == SEND) && word_done;
`endif
      term_fc  = ((state == SEND || state == PRBS) && !rx_block_lock) ? FC_LOST :
                 (state == WAIT_LOCK && !lock_hit && cnt == LOCK_TIMEOUT - 1) ? FC_LOCK :
                 (state == SEND && align_timeout) ? FC_ALIGN :
`ifdef LB_CTRL_PRBS_EN
                 (prbs_end && prbs_bad) ? FC_PRBS :
`endif
                 FC_NONE;
   end

   // Main sequencer: state, counters and every registered output
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         cnt        <= '0;
         tx_cnt     <= '0;
         lock_cnt   <= '0;
         tx_idx     <= '0;
         phy_tx_rst <= 1'b1;
         phy_rx_rst <= 1'b1;
         xgmii_txd  <= DATA_WIDTH'(IDLE_WORD);
         xgmii_txc  <= CTRL_WIDTH'(IDLE_CTRL);
         busy       <= 1'b0;
         done       <= 1'b0;
         pass       <= 1'b0;
         fail_code  <= FC_NONE;
`ifdef LB_CTRL_PRBS_EN
         prbs_on    <= 1'b0;
         prbs_err   <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE, DONE, FAIL: if (start) begin
               state      <= RESET_PHY;
               cnt        <= '0;
               phy_tx_rst <= 1'b1;
               phy_rx_rst <= 1'b1;
               busy       <= 1'b1;
               done       <= 1'b0;
               pass       <= 1'b0;
               fail_code  <= FC_NONE;
            end
            RESET_PHY: begin
               cnt <= cnt + 1;
               if (cnt == RST_CYCLES - 1) begin
                  state      <= WAIT_LOCK;
                  cnt        <= '0;
                  lock_cnt   <= '0;
                  phy_tx_rst <= 1'b0;
                  phy_rx_rst <= 1'b0;
               end
            end
            WAIT_LOCK: begin
               cnt      <= cnt + 1;
               lock_cnt <= lock_ok ? lock_cnt + 5'd1 : 5'd0;
               if (lock_hit) begin
                  state     <= SEND;
                  xgmii_txd <= DATA_WIDTH'(PAT[0]);
                  xgmii_txc <= '0;
                  tx_idx    <= 3'd1;
                  tx_cnt    <= 32'd1;
               end
            end
            SEND: begin
               if (tx_cnt == PATTERN_COUNT) begin
                  xgmii_txd <= DATA_WIDTH'(IDLE_WORD);
                  xgmii_txc <= CTRL_WIDTH'(IDLE_CTRL);
               end else begin
                  xgmii_txd <= DATA_WIDTH'(PAT[tx_idx]);
                  xgmii_txc <= '0;
                  tx_idx    <= pat_next(tx_idx);
                  tx_cnt    <= tx_cnt + 1;
               end
`ifdef LB_CTRL_PRBS_EN
               if (word_done) begin
                  state    <= PRBS;
                  cnt      <= '0;
                  prbs_err <= 1'b0;
                  prbs_on  <= 1'b1;
               end
`endif
            end
`ifdef LB_CTRL_PRBS_EN
            PRBS: begin
               cnt <= cnt + 1;
               if (late_err) prbs_err <= 1'b1;
            end
`endif
            default: state <= IDLE;
         endcase
         if (term_fc != FC_NONE || term_ok) begin
            state     <= (term_fc != FC_NONE) ? FAIL : DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            pass      <= (term_fc == FC_NONE) && (err_count == '0);
            fail_code <= term_fc;
            xgmii_txd <= DATA_WIDTH'(IDLE_WORD);
            xgmii_txc <= CTRL_WIDTH'(IDLE_CTRL);
`ifdef LB_CTRL_PRBS_EN
            prbs_on   <= 1'b0;
`endif
         end
      end
   end
endmodule
